interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter VEC_BASE_RESET, default 8'h40, reset value of the vector base register (bits [2:0] ignored).
REQ-002 clock  input  1  system clock, all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 irq_in  input  7  interrupt sources; source i requests 68000 level i+1.
REQ-005 wr_en  input  1  register write strobe, one clock per write.
REQ-006 addr  input  2  register select.
REQ-007 wdata  input  8  write data.
REQ-008 rdata  output  8  read data, combinational from addr.
REQ-009 ipl_n  output  3  registered active-low interrupt priority level to CPU.
REQ-010 iack  input  1  CPU interrupt-acknowledge cycle in progress, level.
REQ-011 vector  output  8  acknowledge vector number.
REQ-012 vector_valid  output  1  vector is valid for the current iack cycle.

Function
REQ-013 pending[i] SHALL set on a rising edge of irq_in[i]; a level held high SHALL NOT re-set the bit after clearing.
REQ-014 Register map SHALL be: addr0 pending (read; write-1-to-clear), addr1 mask (R/W, 1=enabled), addr2 {vector_base[7:3],3'b000} (R/W), addr3 {5'b0, current level} (read-only; writes ignored).
REQ-015 Same-cycle set edge and write-1-to-clear on the same bit SHALL leave the bit set.
REQ-016 active = pending & mask[6:0]; winner = highest active index; level = winner+1, or 0 if none active.
REQ-017 ipl_n SHALL equal ~level registered, one clock after any pending/mask change.
REQ-018 FSM states IDLE, LATCH, ACK; IDLE->LATCH on iack rising; LATCH->ACK unconditionally; ACK->IDLE when iack low; iack falling in LATCH SHALL go to IDLE with no vector and no clear.
REQ-019 In LATCH, winner SHALL be captured; vector = {vector_base[7:3], winner}, or {vector_base[7:3],3'b111} (spurious) if nothing active.
REQ-020 On the LATCH->ACK transition, the captured pending bit SHALL be cleared (no clear for spurious); vector_valid SHALL be 1 exactly while in ACK.
REQ-021 New edges SHALL continue to set pending in all states; ipl_n SHALL keep tracking during ACK.
REQ-022 vector SHALL hold its last value outside ACK.

Reset
REQ-023 reset_n low SHALL asynchronously force: pending 0, mask 0, vector_base VEC_BASE_RESET[7:3], FSM IDLE, ipl_n 3'b111, vector 8'h00, vector_valid 0, edge/sync history 0.
REQ-024 Reset during LATCH or ACK SHALL abort the acknowledge with no pending bit cleared beyond what was already cleared.

Configuration
REQ-025 Macro INTC_INPUT_SYNC_EN: when defined, each irq_in bit SHALL pass through a 2-flop synchronizer before edge detection, giving irq_in rise -> pending visible after 3 clocks.
REQ-026 When INTC_INPUT_SYNC_EN is undefined, irq_in SHALL be treated as synchronous and pending visible 1 clock after the sampling edge where irq_in=1 and the previous sample was 0.

Structure
REQ-027 Shared package SHALL hold the FSM state enum, register address constants (PEND, MASK, VBASE, STAT), and SPURIOUS_IDX = 3'd7.
REQ-028 One sub-module intc_source SHALL implement per-source sync (optional), edge detection and pending bit with set/clear inputs; instantiated 7 times.

Verification
REQ-029 Macro defined; mask=7'h7F; pulse irq_in[2] -> pending=8'h04 after 3 clocks; ipl_n=3'b100 one clock later.
REQ-030 irq_in[1] and irq_in[5] pending, mask=7'h7F, vector_base=8'h40; assert iack -> vector=8'h45, vector_valid in ACK; pending then 8'h02, ipl_n=3'b101.
REQ-031 mask=0, iack asserted -> vector=8'h47 (spurious), pending unchanged, ipl_n stays 3'b111.
REQ-032 Write addr0 wdata=8'h08 in the same clock as a new irq_in[3] edge -> pending[3]=1.
REQ-033 irq_in[0] held high after iack clears it -> pending[0] stays 0 until irq_in[0] falls and rises again.
REQ-034 Assert reset_n low during ACK -> vector_valid=0, ipl_n=3'b111, FSM IDLE, mask=0 immediately.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared types and constants for the 68000-style interrupt controller.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        ACK   = 2'd2
    } state_t;

    localparam logic [1:0] PEND  = 2'd0;
    localparam logic [1:0] MASK  = 2'd1;
    localparam logic [1:0] VBASE = 2'd2;
    localparam logic [1:0] STAT  = 2'd3;

    localparam logic [2:0] SPURIOUS_IDX = 3'd7;

    // Priority level of the highest active source (index+1), 0 when none.
    function automatic logic [2:0] prio_level(input logic [6:0] act);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (act[i]) lvl = 3'(i + 1);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Register bus and CPU acknowledge signals of the interrupt controller.
interface interrupt_controller_if;
    logic       wr_en;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       iack;
    logic [2:0] ipl_n;
    logic [7:0] vector;
    logic       vector_valid;

    modport master (
        output wr_en, addr, wdata, iack,
        input  rdata, ipl_n, vector, vector_valid
    );

    modport slave (
        input  wr_en, addr, wdata, iack,
        output rdata, ipl_n, vector, vector_valid
    );
endinterface

// File: rtl/interrupt_controller_source.sv
// One interrupt source: optional 2-flop synchronizer, rising-edge detect and
// pending bit. Macro INTC_INPUT_SYNC_EN enables the synchronizer.
module intc_source (
    input  logic clock,
    input  logic reset_n,
    input  logic i_irq,
    input  logic i_clr,
    output logic o_pending
);
    logic w_samp;
    logic w_rise;
    logic r_prev;
    logic r_pending;

`ifdef INTC_INPUT_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-stage synchronizer for an asynchronous request line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_samp = r_sync2;
`else
    assign w_samp = i_irq;
`endif

    assign w_rise = w_samp & ~r_prev;

    // Edge history and pending bit; a new edge wins over a same-cycle clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_prev    <= w_samp;
            r_pending <= w_rise | (r_pending & ~i_clr);
        end
    end

    assign o_pending = r_pending;
endmodule

// File: rtl/interrupt_controller.sv
// 7-source interrupt controller producing 68000 IPL and acknowledge vectors.
// Macro INTC_INPUT_SYNC_EN adds input synchronizers in each source.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter logic [7:0] VEC_BASE_RESET = 8'h40
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [6:0]             irq_in,
    interrupt_controller_if.slave  bus
);
    logic [6:0] w_pending;
    logic [6:0] w_active;
    logic [6:0] w_clr;
    logic [6:0] w_ack_clr;
    logic [6:0] w_wr_clr;
    logic [2:0] w_level;
    logic [2:0] w_winner;
    logic       w_capture;
    state_t     w_next;

    state_t     r_state;
    logic       r_iack_d;
    logic [7:0] r_mask;
    logic [4:0] r_vbase;
    logic [2:0] r_ipl_n;
    logic [7:0] r_vector;

    for (genvar g = 0; g < 7; g++) begin : g_src
        intc_source u_src (
            .clock     (clock),
            .reset_n   (reset_n),
            .i_irq     (irq_in[g]),
            .i_clr     (w_clr[g]),
            .o_pending (w_pending[g])
        );
    end

    assign w_active  = w_pending & r_mask[6:0];
    assign w_level   = prio_level(w_active);
    assign w_winner  = (w_level == 3'd0) ? SPURIOUS_IDX : (w_level - 3'd1);
    assign w_ack_clr = (w_capture && (w_level != 3'd0)) ? (7'd1 << w_winner) : 7'd0;
    assign w_wr_clr  = (bus.wr_en && (bus.addr == PEND)) ? bus.wdata[6:0] : 7'd0;
    assign w_clr     = w_ack_clr | w_wr_clr;

    // Acknowledge FSM next state; capture fires on the LATCH->ACK step.
    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.iack && !r_iack_d) w_next = LATCH;
            end
            LATCH: begin
                if (!bus.iack) begin
                    w_next = IDLE;
                end else begin
                    w_next    = ACK;
                    w_capture = 1'b1;
                end
            end
            ACK: begin
                if (!bus.iack) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM state and iack history for rising-edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_iack_d <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_iack_d <= bus.iack;
        end
    end

    // Writable configuration registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mask  <= 8'h00;
            r_vbase <= VEC_BASE_RESET[7:3];
        end else if (bus.wr_en) begin
            if (bus.addr == MASK)  r_mask  <= bus.wdata;
            if (bus.addr == VBASE) r_vbase <= bus.wdata[7:3];
        end
    end

    // Registered IPL and the vector captured at acknowledge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ipl_n  <= 3'b111;
            r_vector <= 8'h00;
        end else begin
            r_ipl_n <= ~w_level;
            if (w_capture) r_vector <= {r_vbase, w_winner};
        end
    end

    // Combinational register read mux.
    always_comb begin
        bus.rdata = 8'h00;
        case (bus.addr)
            PEND:    bus.rdata = {1'b0, w_pending};
            MASK:    bus.rdata = r_mask;
            VBASE:   bus.rdata = {r_vbase, 3'b000};
            STAT:    bus.rdata = {5'b00000, w_level};
            default: bus.rdata = 8'h00;
        endcase
    end

    assign bus.ipl_n        = r_ipl_n;
    assign bus.vector       = r_vector;
    assign bus.vector_valid = (r_state == ACK);
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller.
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

`ifdef INTC_INPUT_SYNC_EN
    localparam int SYNC_LAT = 3;
`else
    localparam int SYNC_LAT = 1;
`endif

    logic       clock;
    logic       reset_n;
    logic [6:0] irq_in;
    logic [7:0] rd;
    int         n_tests;
    int         n_fail;

    interrupt_controller_if bus();

    interrupt_controller #(.VEC_BASE_RESET(8'h40)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .irq_in  (irq_in),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
        bus.wr_en = 1'b0;
        bus.addr  = PEND;
        bus.wdata = 8'h00;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic test_reset();
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h want 00", rd); end
        read_reg(MASK, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h want 00", rd); end
        read_reg(VBASE, rd);
        n_tests++; if (rd !== 8'h40) begin n_fail++; $display("FAIL reset_vbase: got %h want 40", rd); end
        read_reg(STAT, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_stat: got %h want 00", rd); end
        n_tests++; if (bus.ipl_n !== 3'b111) begin n_fail++; $display("FAIL reset_ipl: got %b want 111", bus.ipl_n); end
        n_tests++; if (bus.vector !== 8'h00) begin n_fail++; $display("FAIL reset_vector: got %h want 00", bus.vector); end
        n_tests++; if (bus.vector_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vvalid: got %b want 0", bus.vector_valid); end
    endtask

    task automatic test_registers();
        write_reg(VBASE, 8'hA5);
        read_reg(VBASE, rd);
        n_tests++; if (rd !== 8'hA0) begin n_fail++; $display("FAIL vbase_rw: got %h want a0", rd); end
        write_reg(VBASE, 8'h40);
        write_reg(STAT, 8'hFF);
        read_reg(STAT, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL stat_ro: got %h want 00", rd); end
        write_reg(MASK, 8'h7F);
        read_reg(MASK, rd);
        n_tests++; if (rd !== 8'h7F) begin n_fail++; $display("FAIL mask_rw: got %h want 7f", rd); end
    endtask

    task automatic test_edge_detect();
        irq_in = 7'b0000100;
        repeat (SYNC_LAT) tick();
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h04) begin n_fail++; $display("FAIL edge_pending: got %h want 04", rd); end
        n_tests++; if (bus.ipl_n !== 3'b111) begin n_fail++; $display("FAIL edge_ipl_lag: got %b want 111", bus.ipl_n); end
        tick();
        n_tests++; if (bus.ipl_n !== 3'b100) begin n_fail++; $display("FAIL edge_ipl: got %b want 100", bus.ipl_n); end
        read_reg(STAT, rd);
        n_tests++; if (rd !== 8'h03) begin n_fail++; $display("FAIL edge_stat: got %h want 03", rd); end
        irq_in = 7'b0000000;
        write_reg(PEND, 8'h04);
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL w1c: got %h want 00", rd); end
        tick();
        n_tests++; if (bus.ipl_n !== 3'b111) begin n_fail++; $display("FAIL w1c_ipl: got %b want 111", bus.ipl_n); end
    endtask

    task automatic test_ack();
        irq_in = 7'b0100010;
        repeat (SYNC_LAT) tick();
        irq_in = 7'b0000000;
        tick();
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h22) begin n_fail++; $display("FAIL ack_pending_pre: got %h want 22", rd); end
        n_tests++; if (bus.ipl_n !== 3'b001) begin n_fail++; $display("FAIL ack_ipl_pre: got %b want 001", bus.ipl_n); end
        bus.iack = 1'b1;
        tick();
        n_tests++; if (bus.vector_valid !== 1'b0) begin n_fail++; $display("FAIL ack_latch_vvalid: got %b want 0", bus.vector_valid); end
        tick();
        n_tests++; if (bus.vector_valid !== 1'b1) begin n_fail++; $display("FAIL ack_vvalid: got %b want 1", bus.vector_valid); end
        n_tests++; if (bus.vector !== 8'h45) begin n_fail++; $display("FAIL ack_vector: got %h want 45", bus.vector); end
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h02) begin n_fail++; $display("FAIL ack_pending_post: got %h want 02", rd); end
        tick();
        n_tests++; if (bus.ipl_n !== 3'b101) begin n_fail++; $display("FAIL ack_ipl_post: got %b want 101", bus.ipl_n); end
        bus.iack = 1'b0;
        tick();
        n_tests++; if (bus.vector_valid !== 1'b0) begin n_fail++; $display("FAIL ack_idle_vvalid: got %b want 0", bus.vector_valid); end
        n_tests++; if (bus.vector !== 8'h45) begin n_fail++; $display("FAIL ack_vector_hold: got %h want 45", bus.vector); end
        write_reg(PEND, 8'h02);
        tick();
    endtask

    task automatic test_spurious();
        write_reg(MASK, 8'h00);
        irq_in = 7'b0010000;
        repeat (SYNC_LAT) tick();
        irq_in = 7'b0000000;
        tick();
        bus.iack = 1'b1;
        tick();
        tick();
        n_tests++; if (bus.vector !== 8'h47) begin n_fail++; $display("FAIL spur_vector: got %h want 47", bus.vector); end
        n_tests++; if (bus.vector_valid !== 1'b1) begin n_fail++; $display("FAIL spur_vvalid: got %b want 1", bus.vector_valid); end
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h10) begin n_fail++; $display("FAIL spur_pending: got %h want 10", rd); end
        n_tests++; if (bus.ipl_n !== 3'b111) begin n_fail++; $display("FAIL spur_ipl: got %b want 111", bus.ipl_n); end
        bus.iack = 1'b0;
        tick();
        write_reg(PEND, 8'h10);
        write_reg(MASK, 8'h7F);
        tick();
    endtask

    task automatic test_set_clear_collision();
        irq_in = 7'b0001000;
        repeat (SYNC_LAT - 1) tick();
        write_reg(PEND, 8'h08);
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h08) begin n_fail++; $display("FAIL collide_set_wins: got %h want 08", rd); end
        write_reg(PEND, 8'h08);
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL collide_then_clear: got %h want 00", rd); end
        irq_in = 7'b0000000;
        tick();
        tick();
    endtask

    task automatic test_level_held();
        irq_in = 7'b0000001;
        repeat (SYNC_LAT) tick();
        tick();
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h01) begin n_fail++; $display("FAIL held_pending_set: got %h want 01", rd); end
        bus.iack = 1'b1;
        tick();
        tick();
        n_tests++; if (bus.vector !== 8'h40) begin n_fail++; $display("FAIL held_vector: got %h want 40", bus.vector); end
        bus.iack = 1'b0;
        repeat (4) tick();
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL held_no_reset: got %h want 00", rd); end
        irq_in = 7'b0000000;
        repeat (SYNC_LAT) tick();
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL held_fall: got %h want 00", rd); end
        irq_in = 7'b0000001;
        repeat (SYNC_LAT) tick();
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h01) begin n_fail++; $display("FAIL held_rerise: got %h want 01", rd); end
    endtask

    task automatic test_latch_abort();
        bus.iack = 1'b1;
        tick();
        bus.iack = 1'b0;
        tick();
        n_tests++; if (bus.vector_valid !== 1'b0) begin n_fail++; $display("FAIL abort_vvalid: got %b want 0", bus.vector_valid); end
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h01) begin n_fail++; $display("FAIL abort_pending: got %h want 01", rd); end
        tick();
        n_tests++; if (bus.vector_valid !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got %b want 0", bus.vector_valid); end
    endtask

    task automatic test_reset_in_ack();
        irq_in = 7'b1000001;
        repeat (SYNC_LAT) tick();
        tick();
        bus.iack = 1'b1;
        tick();
        tick();
        n_tests++; if (bus.vector_valid !== 1'b1) begin n_fail++; $display("FAIL rst_ack_vvalid_pre: got %b want 1", bus.vector_valid); end
        n_tests++; if (bus.vector !== 8'h46) begin n_fail++; $display("FAIL rst_ack_vector_pre: got %h want 46", bus.vector); end
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h01) begin n_fail++; $display("FAIL rst_ack_pending_pre: got %h want 01", rd); end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (bus.vector_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ack_vvalid: got %b want 0", bus.vector_valid); end
        n_tests++; if (bus.ipl_n !== 3'b111) begin n_fail++; $display("FAIL rst_ack_ipl: got %b want 111", bus.ipl_n); end
        n_tests++; if (bus.vector !== 8'h00) begin n_fail++; $display("FAIL rst_ack_vector: got %h want 00", bus.vector); end
        read_reg(MASK, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rst_ack_mask: got %h want 00", rd); end
        read_reg(PEND, rd);
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL rst_ack_pending: got %h want 00", rd); end
        irq_in   = 7'b0000000;
        bus.iack = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        n_tests++; if (bus.vector_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ack_idle: got %b want 0", bus.vector_valid); end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        irq_in    = 7'b0000000;
        bus.wr_en = 1'b0;
        bus.addr  = PEND;
        bus.wdata = 8'h00;
        bus.iack  = 1'b0;
        #22;
        reset_n = 1'b1;
        tick();

        test_reset();
        test_registers();
        test_edge_detect();
        test_ack();
        test_spurious();
        test_set_clear_collision();
        test_level_held();
        test_latch_abort();
        test_reset_in_ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
